cfg_lut_seq: RTL and testbench



---
 rtl/cfg_lut_pkg.sv | 15 +
 rtl/cfg_lut_ctrl.sv | 72 +++++++
 rtl/cfg_lut_seq.sv | 80 ++++++++
 tb/tb_cfg_lut_seq.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/cfg_lut_pkg.sv
// Shared types and constants for the serially reconfigurable LUT cell (cfg_lut_seq).
package cfg_lut_pkg;

  localparam int unsigned MAX_WIDTH = 6;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_LOAD = 1'b1
  } state_t;

  function automatic int unsigned lut_bits(input int unsigned width);
    return 32'd1 << width;
  endfunction

endpackage

// File: rtl/cfg_lut_ctrl.sv
// Load controller for cfg_lut_seq: FSM, beat counter, handshake and commit strobe.
module cfg_lut_ctrl
  import cfg_lut_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_arst_n,
  input  logic             i_start,
  input  logic             i_valid,
  output logic             o_ready,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_accept,
  output logic             o_commit,
  output logic [WIDTH-1:0] o_idx
);

  localparam logic [WIDTH:0] LAST = (WIDTH+1)'(lut_bits(WIDTH) - 1);

  state_t           r_state;
  state_t           w_state_nx;
  logic [WIDTH:0]   r_count;
  logic [WIDTH:0]   w_count_nx;
  logic             r_done;

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      r_state <= ST_RUN;
      r_count <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_count <= w_count_nx;
      r_done  <= o_commit;
    end
  end

  // A start pulse always wins over a coincident beat, including the final one.
  always_comb begin
    w_state_nx = r_state;
    w_count_nx = r_count;
    o_accept   = 1'b0;
    o_commit   = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (i_start) begin
          w_state_nx = ST_LOAD;
          w_count_nx = '0;
        end
      end
      ST_LOAD: begin
        if (i_start) begin
          w_count_nx = '0;
        end else if (i_valid) begin
          o_accept   = 1'b1;
          w_count_nx = r_count + 1'b1;
          if (r_count == LAST) begin
            o_commit   = 1'b1;
            w_state_nx = ST_RUN;
          end
        end
      end
    endcase
  end

  assign o_ready = (r_state == ST_LOAD);
  assign o_busy  = (r_state == ST_LOAD);
  assign o_done  = r_done;
  assign o_idx   = r_count[WIDTH-1:0];

endmodule

// File: rtl/cfg_lut_seq.sv
// Serially configurable k-input LUT with shadow-table reload.
// Optional table readback during load enabled by defining CFG_LUT_READBACK_EN.
module cfg_lut_seq
  import cfg_lut_pkg::*;
#(
  parameter int unsigned                 WIDTH = 4,
  parameter logic [lut_bits(WIDTH)-1:0]  INIT  = '0
) (
  input  logic             CLK,
  input  logic             ARST_N,
  input  logic [WIDTH-1:0] A,
  output logic             Y,
  output logic             Y_VALID,
  input  logic             CFG_START,
  input  logic             CFG_DATA,
  input  logic             CFG_VALID,
  output logic             CFG_READY,
  output logic             CFG_DONE,
`ifdef CFG_LUT_READBACK_EN
  output logic             RB_DATA,
`endif
  output logic             CFG_BUSY
);

  localparam int unsigned NBITS = lut_bits(WIDTH);

  if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_bad_width
    $error("cfg_lut_seq: WIDTH out of range");
  end

  logic [NBITS-1:0] r_active;
  logic [NBITS-1:0] r_shadow;
  logic [NBITS-1:0] w_merged;
  logic             r_y;
  logic             r_y_valid;
  logic             w_accept;
  logic             w_commit;
  logic [WIDTH-1:0] w_idx;

  cfg_lut_ctrl #(.WIDTH(WIDTH)) u_ctrl (
    .i_clk    (CLK),
    .i_arst_n (ARST_N),
    .i_start  (CFG_START),
    .i_valid  (CFG_VALID),
    .o_ready  (CFG_READY),
    .o_busy   (CFG_BUSY),
    .o_done   (CFG_DONE),
    .o_accept (w_accept),
    .o_commit (w_commit),
    .o_idx    (w_idx)
  );

  // The final beat is folded in directly so the commit needs no extra cycle.
  always_comb begin
    w_merged        = r_shadow;
    w_merged[w_idx] = CFG_DATA;
  end

  always_ff @(posedge CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      r_active  <= INIT;
      r_shadow  <= '0;
      r_y       <= 1'b0;
      r_y_valid <= 1'b0;
    end else begin
      r_y       <= r_active[A];
      r_y_valid <= 1'b1;
      if (w_accept) r_shadow[w_idx] <= CFG_DATA;
      if (w_commit) r_active <= w_merged;
    end
  end

  assign Y       = r_y;
  assign Y_VALID = r_y_valid;

`ifdef CFG_LUT_READBACK_EN
  assign RB_DATA = CFG_BUSY ? r_active[w_idx] : 1'b0;
`endif

endmodule

// File: tb/tb_cfg_lut_seq.sv
// Directed self-checking bench for cfg_lut_seq (WIDTH=2, INIT=AND table 4'b1000).
module tb_cfg_lut_seq;

  logic       CLK = 1'b0;
  logic       ARST_N;
  logic [1:0] A;
  logic       Y, Y_VALID;
  logic       CFG_START, CFG_DATA, CFG_VALID;
  logic       CFG_READY, CFG_DONE, CFG_BUSY;
`ifdef CFG_LUT_READBACK_EN
  logic       RB_DATA;
`endif

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  int done_base;

  cfg_lut_seq #(.WIDTH(2), .INIT(4'b1000)) dut (
    .CLK       (CLK),
    .ARST_N    (ARST_N),
    .A         (A),
    .Y         (Y),
    .Y_VALID   (Y_VALID),
    .CFG_START (CFG_START),
    .CFG_DATA  (CFG_DATA),
    .CFG_VALID (CFG_VALID),
    .CFG_READY (CFG_READY),
    .CFG_DONE  (CFG_DONE),
`ifdef CFG_LUT_READBACK_EN
    .RB_DATA   (RB_DATA),
`endif
    .CFG_BUSY  (CFG_BUSY)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) if (CFG_DONE === 1'b1) done_cnt++;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %b want %b", tag, got, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  task automatic start_pulse();
    CFG_START = 1'b1;
    tick();
    CFG_START = 1'b0;
  endtask

  // bits[i] is sent as beat i; stall idle cycles are inserted between beats.
  task automatic beats(input logic [3:0] bits, input int n, input int stall);
    for (int i = 0; i < n; i++) begin
      CFG_DATA  = bits[i];
      CFG_VALID = 1'b1;
      tick();
      CFG_VALID = 1'b0;
      if (i < n - 1) begin
        for (int s = 0; s < stall; s++) begin
          tick();
          chk("stall_busy", CFG_BUSY, 1'b1);
          chk("stall_no_done", CFG_DONE, 1'b0);
        end
      end
    end
  endtask

  task automatic check_table(input string tag, input logic [3:0] exp);
    for (int a = 0; a < 4; a++) begin
      A = 2'(a);
      tick();
      chk(tag, Y, exp[a]);
    end
  endtask

  initial begin
    ARST_N = 1'b0; A = '0;
    CFG_START = 1'b0; CFG_DATA = 1'b0; CFG_VALID = 1'b0;
    repeat (2) tick();
    chk("rst_y", Y, 1'b0);
    chk("rst_yvalid", Y_VALID, 1'b0);
    chk("rst_ready", CFG_READY, 1'b0);
    chk("rst_busy", CFG_BUSY, 1'b0);
    chk("rst_done", CFG_DONE, 1'b0);

    ARST_N = 1'b1;
    A = 2'd3;
    tick();
    chk("and_a3", Y, 1'b1);
    chk("and_yvalid", Y_VALID, 1'b1);
    A = 2'd2;
    tick();
    chk("and_a2", Y, 1'b0);

    // XOR load, valid held high, A=3 watched throughout
    done_base = done_cnt;
    start_pulse();
    chk("xor_busy", CFG_BUSY, 1'b1);
    chk("xor_ready", CFG_READY, 1'b1);
    A = 2'd3;
    for (int i = 0; i < 4; i++) begin
      CFG_DATA  = (i == 1 || i == 2);
      CFG_VALID = 1'b1;
      tick();
      if (i < 3) begin
        chk("xor_y_old", Y, 1'b1);
        chk("xor_no_done", CFG_DONE, 1'b0);
      end
    end
    CFG_VALID = 1'b0;
    chk("xor_done", CFG_DONE, 1'b1);
    chk("xor_busy_clr", CFG_BUSY, 1'b0);
    chk("xor_ready_clr", CFG_READY, 1'b0);
    chk("xor_commit_y_old", Y, 1'b1);
    tick();
    chk("xor_done_clr", CFG_DONE, 1'b0);
    chk("xor_y_new", Y, 1'b0);
    chk_int("xor_done_count", done_cnt - done_base, 1);
    A = 2'd1;
    tick();
    chk("xor_a1", Y, 1'b1);
    check_table("xor_table", 4'b0110);

    // Stalled load
    done_base = done_cnt;
    start_pulse();
    beats(4'b0110, 4, 3);
    tick();
    chk_int("stall_done_count", done_cnt - done_base, 1);
    check_table("stall_table", 4'b0110);

    // Start coincident with the last beat: no commit
    done_base = done_cnt;
    start_pulse();
    beats(4'b0001, 3, 0);
    CFG_DATA = 1'b1; CFG_VALID = 1'b1; CFG_START = 1'b1;
    tick();
    CFG_VALID = 1'b0; CFG_START = 1'b0;
    chk("last_start_busy", CFG_BUSY, 1'b1);
    chk("last_start_no_done", CFG_DONE, 1'b0);
    tick();
    chk_int("last_start_done_count", done_cnt - done_base, 0);
    beats(4'b1001, 4, 0);
    tick();
    chk_int("last_reload_done_count", done_cnt - done_base, 1);
    check_table("last_reload_table", 4'b1001);

    // Start coincident with the 3rd beat: beat discarded
    done_base = done_cnt;
    start_pulse();
    beats(4'b0001, 2, 0);
    CFG_DATA = 1'b1; CFG_VALID = 1'b1; CFG_START = 1'b1;
    tick();
    CFG_VALID = 1'b0; CFG_START = 1'b0;
    chk("restart_busy", CFG_BUSY, 1'b1);
    beats(4'b0111, 4, 0);
    tick();
    chk_int("restart_done_count", done_cnt - done_base, 1);
    check_table("restart_table", 4'b0111);

    // Reset in mid-load
    done_base = done_cnt;
    start_pulse();
    beats(4'b0110, 2, 0);
    ARST_N = 1'b0;
    #1;
    chk("midrst_ready", CFG_READY, 1'b0);
    chk("midrst_busy", CFG_BUSY, 1'b0);
    chk("midrst_y", Y, 1'b0);
    chk("midrst_yvalid", Y_VALID, 1'b0);
    tick();
    ARST_N = 1'b1;
    A = 2'd3;
    tick();
    chk("midrst_a3", Y, 1'b1);
    chk("midrst_ready_after", CFG_READY, 1'b0);
    check_table("midrst_table", 4'b1000);
    chk_int("midrst_done_count", done_cnt - done_base, 0);

`ifdef CFG_LUT_READBACK_EN
    begin
      logic [3:0] rb_exp;
      logic [3:0] new_tbl;
      rb_exp  = 4'b1000;
      new_tbl = 4'b0110;
      chk("rb_run_zero", RB_DATA, 1'b0);
      start_pulse();
      for (int i = 0; i < 4; i++) begin
        CFG_DATA  = new_tbl[i];
        CFG_VALID = 1'b1;
        #1;
        chk("rb_beat", RB_DATA, rb_exp[i]);
        tick();
      end
      CFG_VALID = 1'b0;
      chk("rb_after_zero", RB_DATA, 1'b0);
      tick();
      check_table("rb_table", 4'b0110);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
